// File: rtl/tpu_acc_pkg.sv
// Shared types and helpers for the systolic-array output accumulator bank.
// sat_add is only used when ACC_SATURATE_EN is defined.
package tpu_acc_pkg;

    typedef enum logic {
        ACC_FILL  = 1'b0,
        ACC_DRAIN = 1'b1
    } acc_state_t;

    localparam int ACC_DATA_W = 32;
    localparam int ACC_MAX_W  = 64;

    typedef struct packed {
        logic                        clamp;
        logic signed [ACC_MAX_W-1:0] val;
    } sat_res_t;

    // Operands arrive sign-extended to ACC_MAX_W; the clamp limits follow the true width w.
    function automatic sat_res_t sat_add(input logic signed [ACC_MAX_W-1:0] a,
                                         input logic signed [ACC_MAX_W-1:0] b,
                                         input int w);
        logic signed [ACC_MAX_W:0] one;
        logic signed [ACC_MAX_W:0] sum;
        logic signed [ACC_MAX_W:0] max_v;
        logic signed [ACC_MAX_W:0] min_v;
        sat_res_t r;
        one   = {{ACC_MAX_W{1'b0}}, 1'b1};
        sum   = {a[ACC_MAX_W-1], a} + {b[ACC_MAX_W-1], b};
        max_v = (one <<< (w - 1)) - one;
        min_v = -(one <<< (w - 1));
        r.clamp = 1'b0;
        r.val   = sum[ACC_MAX_W-1:0];
        if (sum > max_v) begin
            r.clamp = 1'b1;
            r.val   = max_v[ACC_MAX_W-1:0];
        end else if (sum < min_v) begin
            r.clamp = 1'b1;
            r.val   = min_v[ACC_MAX_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/tpu_acc_bank_if.sv
// Row-in / row-out stream bundle of the accumulator bank.
// master = array side and writeback consumer, slave = the bank.
interface tpu_acc_bank_if
    import tpu_acc_pkg::*;
#(
    parameter int DATA_W   = ACC_DATA_W,
    parameter int NUM_COLS = 2
);
    logic                       in_valid;
    logic                       in_ready;
    logic [NUM_COLS*DATA_W-1:0] in_data;
    logic                       pass_last;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_COLS*DATA_W-1:0] out_data;
    logic                       out_last;
    logic                       full;
    logic                       ovf;

    modport master (
        output in_valid, in_data, pass_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, full, ovf
    );

    modport slave (
        input  in_valid, in_data, pass_last, out_ready,
        output in_ready, out_valid, out_data, out_last, full, ovf
    );
endinterface

// File: rtl/tpu_acc_lane.sv
// One column of the accumulator: overwrite on first pass, otherwise add.
// ACC_SATURATE_EN selects a clamping add with an overflow strobe; default wraps.
module tpu_acc_lane
    import tpu_acc_pkg::*;
#(
    parameter int DATA_W = ACC_DATA_W
) (
    input  logic                     first_pass,
    input  logic signed [DATA_W-1:0] stored,
    input  logic signed [DATA_W-1:0] in_val,
    output logic signed [DATA_W-1:0] result,
    output logic                     ovf_hit
);
    logic signed [DATA_W-1:0] sum;
    logic                     clamp;

`ifdef ACC_SATURATE_EN
    sat_res_t sat;
    assign sat   = sat_add(ACC_MAX_W'(stored), ACC_MAX_W'(in_val), DATA_W);
    assign sum   = sat.val[DATA_W-1:0];
    assign clamp = sat.clamp;
`else
    assign sum   = stored + in_val;
    assign clamp = 1'b0;
`endif

    // The overwrite path bypasses the adder, so it can never flag a clamp.
    assign result  = first_pass ? in_val : sum;
    assign ovf_hit = clamp & ~first_pass;
endmodule

// File: rtl/tpu_acc_bank.sv
// Output accumulator bank: sums K-tile passes into DEPTH rows, then drains the tile.
// Saturating accumulation and the ovf flag are enabled by defining ACC_SATURATE_EN.
//
// state     | meaning
// ACC_FILL  | accepting rows, overwrite on first pass, add on later passes
// ACC_DRAIN | tile complete, streaming mem[rd_ptr] out, input stalled
module tpu_acc_bank
    import tpu_acc_pkg::*;
#(
    parameter int DATA_W   = ACC_DATA_W,
    parameter int DEPTH    = 4,
    parameter int NUM_COLS = 2
) (
    input  logic           clk,
    input  logic           reset,
    tpu_acc_bank_if.slave  bus
);
    localparam int ROW_W = NUM_COLS * DATA_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    acc_state_t       state;
    acc_state_t       state_nxt;
    logic [ROW_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             first_pass;
    logic             ovf_q;

    logic             wr_fire;
    logic             rd_fire;
    logic             wr_last;
    logic             rd_last;
    logic [ROW_W-1:0] wr_row;
    logic [ROW_W-1:0] row_new;
    logic [NUM_COLS-1:0] lane_ovf;

    assign wr_last = (wr_ptr == PTR_W'(DEPTH - 1));
    assign rd_last = (rd_ptr == PTR_W'(DEPTH - 1));
    assign wr_fire = bus.in_valid & bus.in_ready;
    assign rd_fire = bus.out_valid & bus.out_ready;
    assign wr_row  = mem[wr_ptr];

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_lane
        tpu_acc_lane #(.DATA_W(DATA_W)) u_lane (
            .first_pass (first_pass),
            .stored     (wr_row[c*DATA_W +: DATA_W]),
            .in_val     (bus.in_data[c*DATA_W +: DATA_W]),
            .result     (row_new[c*DATA_W +: DATA_W]),
            .ovf_hit    (lane_ovf[c])
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC_FILL: begin
                if (wr_fire && wr_last && bus.pass_last) state_nxt = ACC_DRAIN;
            end
            ACC_DRAIN: begin
                if (rd_fire && rd_last) state_nxt = ACC_FILL;
            end
            default: state_nxt = ACC_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ACC_FILL;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            first_pass <= 1'b1;
            ovf_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state <= state_nxt;
            if (wr_fire) begin
                mem[wr_ptr] <= row_new;
                ovf_q       <= ovf_q | (|lane_ovf);
                if (wr_last) begin
                    wr_ptr     <= '0;
                    first_pass <= 1'b0;
                end else begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
            end
            // Memory is left intact after a drain; the next first pass overwrites it.
            if (rd_fire) begin
                if (rd_last) begin
                    rd_ptr     <= '0;
                    ovf_q      <= 1'b0;
                    first_pass <= 1'b1;
                end else begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    assign bus.in_ready  = (state == ACC_FILL);
    assign bus.out_valid = (state == ACC_DRAIN);
    assign bus.full      = (state == ACC_DRAIN);
    assign bus.out_data  = mem[rd_ptr];
    assign bus.out_last  = (state == ACC_DRAIN) && rd_last;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_tpu_acc_bank.sv
// Scoreboard bench for tpu_acc_bank (DATA_W=32, DEPTH=4, NUM_COLS=2).
// Expected overflow results follow ACC_SATURATE_EN.
module tb_tpu_acc_bank;
    localparam int DW = 32;
    localparam int NC = 2;
    localparam int DP = 4;
`ifdef ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [NC*DW-1:0] data;
        logic             last;
        logic             ovf;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    exp_t exp_q[$];
    exp_t e;

    tpu_acc_bank_if #(.DATA_W(DW), .NUM_COLS(NC)) bus ();

    tpu_acc_bank #(.DATA_W(DW), .DEPTH(DP), .NUM_COLS(NC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NC*DW-1:0] row(input logic [DW-1:0] c0, input logic [DW-1:0] c1);
        return {c1, c0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    function automatic void expect_row(input logic [NC*DW-1:0] d, input logic last, input logic ovf);
        exp_t x;
        x.data = d;
        x.last = last;
        x.ovf  = ovf;
        exp_q.push_back(x);
    endfunction

    function automatic void expect_tile(input logic [NC*DW-1:0] r0, input logic [NC*DW-1:0] r1,
                                        input logic [NC*DW-1:0] r2, input logic [NC*DW-1:0] r3,
                                        input logic ovf);
        expect_row(r0, 1'b0, ovf);
        expect_row(r1, 1'b0, ovf);
        expect_row(r2, 1'b0, ovf);
        expect_row(r3, 1'b1, ovf);
    endfunction

    // Monitor: compares every drained row against the head of the scoreboard.
    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_row: got %h expected none", bus.out_data);
            end else begin
                e = exp_q.pop_front();
                check("row_data", bus.out_data, e.data);
                check("row_last", bus.out_last, e.last);
                check("row_ovf", bus.ovf, e.ovf);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_row(input logic [NC*DW-1:0] d, input logic pl);
        bit done;
        done = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.pass_last = pl;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.pass_last = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
        end
    endtask

    task automatic send_tile(input logic [NC*DW-1:0] r0, input logic [NC*DW-1:0] r1,
                             input logic [NC*DW-1:0] r2, input logic [NC*DW-1:0] r3,
                             input logic pl);
        send_row(r0, 1'b0);
        send_row(r1, 1'b0);
        send_row(r2, 1'b0);
        send_row(r3, pl);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d rows pending expected 0", exp_q.size());
        end
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_empty();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("in_ready_after_drain", bus.in_ready, 1'b1);
        check("ovf_after_drain", bus.ovf, 1'b0);
    endtask

    task automatic check_full(input logic ovf);
        @(negedge clk);
        check("full_rise", bus.full, 1'b1);
        check("out_valid_rise", bus.out_valid, 1'b1);
        check("in_ready_drain", bus.in_ready, 1'b0);
        check("ovf_before_drain", bus.ovf, ovf);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.pass_last = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_out_data", bus.out_data, '0);
        check("rst_full", bus.full, 1'b0);
        check("rst_ovf", bus.ovf, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // single pass
        send_tile(row(1, 2), row(3, 4), row(5, 6), row(7, 8), 1'b1);
        expect_tile(row(1, 2), row(3, 4), row(5, 6), row(7, 8), 1'b0);
        check_full(1'b0);
        drain();

        // two passes; pass_last on a non-final row must be ignored
        send_row(row(10, 20), 1'b1);
        send_row(row(10, 20), 1'b0);
        send_row(row(10, 20), 1'b0);
        send_row(row(10, 20), 1'b0);
        @(negedge clk);
        check("no_drain_mid_tile", bus.in_ready, 1'b1);
        check("no_full_mid_tile", bus.full, 1'b0);
        @(posedge clk);
        #1;
        send_tile(row(1, -1), row(1, -1), row(1, -1), row(1, -1), 1'b1);
        expect_tile(row(11, 19), row(11, 19), row(11, 19), row(11, 19), 1'b0);
        check_full(1'b0);
        drain();

        // zero rows are real data
        send_tile(row(0, 0), row(0, 0), row(0, 0), row(5, 5), 1'b1);
        expect_tile(row(0, 0), row(0, 0), row(0, 0), row(5, 5), 1'b0);
        check_full(1'b0);
        drain();

        // backpressure with in_valid held during drain
        send_tile(row(100, 200), row(300, 400), row(500, 600), row(700, 800), 1'b1);
        expect_tile(row(100, 200), row(300, 400), row(500, 600), row(700, 800), 1'b0);
        bus.in_valid  = 1'b1;
        bus.in_data   = row(999, 999);
        bus.pass_last = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_out_data", bus.out_data, row(300, 400));
            check("stall_in_ready", bus.in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        drain();
        bus.pass_last = 1'b0;

        // overflow in both directions on col0
        send_tile(row(32'h7FFF_FFFF, 5), row(32'h8000_0000, 7), row(1, 1), row(1, 1), 1'b0);
        send_tile(row(1, -3), row(-1, 1), row(2, 2), row(2, 2), 1'b1);
        if (SAT) expect_tile(row(32'h7FFF_FFFF, 2), row(32'h8000_0000, 8), row(3, 3), row(3, 3), 1'b1);
        else     expect_tile(row(32'h8000_0000, 2), row(32'h7FFF_FFFF, 8), row(3, 3), row(3, 3), 1'b0);
        check_full(SAT);
        drain();

        // reset in the middle of a drain
        send_tile(row(21, 22), row(23, 24), row(25, 26), row(27, 28), 1'b1);
        expect_row(row(21, 22), 1'b0, 1'b0);
        expect_row(row(23, 24), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_empty();
        bus.out_ready = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_in_ready", bus.in_ready, 1'b1);
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_out_last", bus.out_last, 1'b0);
        check("midrst_out_data", bus.out_data, '0);
        check("midrst_full", bus.full, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        send_tile(row(9, 9), row(9, 9), row(9, 9), row(9, 9), 1'b1);
        expect_tile(row(9, 9), row(9, 9), row(9, 9), row(9, 9), 1'b0);
        check_full(1'b0);
        drain();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/tpu_acc_bank.md
# tpu_acc_bank

Parametrised output accumulator bank for the systolic array: buffers DEPTH rows of NUM_COLS signed partial sums, adds successive K-tile passes into the stored rows, then drains the finished tile over a valid/ready stream. Sits between the bottom edge of the systolic array and the result writeback path. Zero is a valid datum: every handshaked row is stored or added.

## Interface
- DATA_W, 32, width of one column value (signed two's complement)
- DEPTH, 4, rows per tile (≥2)
- NUM_COLS, 2, columns per row
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- in_valid  input  1  row present on in_data
- in_ready  output  1  bank accepts a row (high only in FILL)
- in_data  input  NUM_COLS*DATA_W  column c at [c*DATA_W +: DATA_W]
- pass_last  input  1  qualifies in_valid: current pass is the final K-pass of the tile
- out_valid  output  1  drained row valid (high only in DRAIN)
- out_ready  input  1  consumer accepts row
- out_data  output  NUM_COLS*DATA_W  row at rd_ptr, same packing as in_data
- out_last  output  1  out_valid && rd_ptr==DEPTH-1
- full  output  1  tile complete, drain in progress
- ovf  output  1  sticky overflow flag, cleared at drain end

## Operation
- States: FILL, DRAIN. Reset: FILL, wr_ptr=0, rd_ptr=0, first_pass=1, all mem=0, full=0, ovf=0; hence in_ready=1, out_valid=0, out_last=0, out_data=0.
- FILL, in_valid&&in_ready: mem[wr_ptr] <= first_pass ? in_data : mem[wr_ptr]+in_data, per column, independent lanes.
- wr_ptr increments; at DEPTH-1 wraps to 0 and first_pass<=0.
- Row DEPTH-1 accepted with pass_last=1: -> DRAIN, full<=1. pass_last on other rows ignored.
- DRAIN: in_ready=0, in_valid ignored. out_data = mem[rd_ptr] (combinational read of registered array, stable while stalled).
- out_valid&&out_ready: rd_ptr++; on rd_ptr==DEPTH-1 -> FILL, rd_ptr=0, full=0, ovf=0, first_pass=1. Memory not cleared; next first pass overwrites.
- Add width: DATA_W result; wrap or saturate per Configuration.
- Reset asserted mid-operation: immediate return to reset values, partial tile discarded.

## Timing
- Write: row visible in mem the cycle after handshake.
- full and out_valid rise the cycle after the final row handshake.
- Drain: DEPTH handshakes, minimum DEPTH cycles; out_ready low stalls without loss.
- in_ready rises the cycle after the out_last handshake; a row may be accepted that cycle.
- Minimum tile turnaround with one pass: 2*DEPTH cycles.

## Configuration
- ACC_SATURATE_EN defined: signed saturating add, result clamped to 2^(DATA_W-1)-1 / -2^(DATA_W-1); any clamp sets ovf.
- Undefined: two's complement wrap-around; ovf tied to 0.
- First-pass overwrite never saturates either way.

## Structure
- Package tpu_acc_pkg: acc_state_t enum {ACC_FILL, ACC_DRAIN}, ACC_DATA_W default constant, sat_add function.
- Sub-module tpu_acc_lane: one column's add/overwrite (+ optional saturation, overflow out), instantiated NUM_COLS times; bank owns pointers, FSM, memory.

## Test plan
(DATA_W=32, DEPTH=4, NUM_COLS=2, values as (col0,col1))
- Single pass (1,2),(3,4),(5,6),(7,8), pass_last on row 3 -> full=1 next cycle; drain emits same four rows in order, out_last on (7,8), then in_ready=1.
- Two passes: all rows (10,20), then all rows (1,-1) with pass_last -> drain emits (11,19) ×4.
- Zero rows (0,0),(0,0),(0,0),(5,5) single pass -> all four accepted, drain (0,0)×3,(5,5).
- Backpressure: out_ready low 3 cycles after first drained row -> out_data constant, rd_ptr held; in_valid=1 throughout drain -> in_ready=0, mem unchanged.
- Overflow: pass 1 col0=0x7FFFFFFF, pass 2 col0=1 -> with ACC_SATURATE_EN 0x7FFFFFFF and ovf=1; without 0x80000000, ovf=0; ovf clears after drain.
- Reset low mid-drain after 2 rows -> all outputs at reset values; next single pass (9,9)×4 drains (9,9)×4.
